// File: rtl/obstacle_controller.sv
// Per-frame motion and collision controller for one 32x32 obstacle sprite.
// Position, score and state advance on the vsync rising edge; start and reset act on any edge.
module obstacle_controller #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SPRITE_W  = 32,
  parameter int unsigned Y_MIN     = 96,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic [3:0] speed,
  input  logic       overlap,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       running,
  output logic       game_over,
  output logic       collision,
  output logic [7:0] score
);

  localparam logic [9:0] ParkX = 10'(SCREEN_W);
  localparam logic [9:0] YMin  = 10'(Y_MIN);

  typedef enum logic [1:0] {StIdle, StMove, StHit} state_e;

  state_e      state_q;
  logic        vsync_q;
  logic        hit_seen_q;
  logic [15:0] lfsr_q;

  logic        tick;
  logic        hit_acc;
  logic        launch;
  logic [9:0]  step;
  logic [15:0] lfsr_next;

  // Sprite width only documents the bounds; the motion logic never needs it.
  logic unused_sprite_w;
  assign unused_sprite_w = ^SPRITE_W;

  assign tick      = vsync & ~vsync_q;
  assign hit_acc   = hit_seen_q | overlap;
  assign launch    = start && (state_q != StMove);
  assign step      = (speed == 4'd0) ? 10'd1 : {6'd0, speed};
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      vsync_q    <= 1'b1;
      hit_seen_q <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      sprite_x   <= ParkX;
      sprite_y   <= YMin;
      score      <= 8'd0;
      running    <= 1'b0;
      game_over  <= 1'b0;
      collision  <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      collision  <= 1'b0;
      // The tick cycle's overlap is folded into hit_acc for the closing frame.
      hit_seen_q <= tick ? 1'b0 : hit_acc;
      if (launch) begin
        state_q    <= StMove;
        running    <= 1'b1;
        game_over  <= 1'b0;
        sprite_x   <= ParkX;
        sprite_y   <= YMin + {2'd0, lfsr_q[7:0]};
        score      <= 8'd0;
        hit_seen_q <= 1'b0;
      end else if (state_q == StMove && tick) begin
        lfsr_q <= lfsr_next;
        if (hit_acc) begin
          state_q   <= StHit;
          running   <= 1'b0;
          game_over <= 1'b1;
          collision <= 1'b1;
        end else if (sprite_x < step) begin
          sprite_x <= ParkX;
          sprite_y <= YMin + {2'd0, lfsr_next[7:0]};
          if (score != 8'd255) begin
            score <= score + 8'd1;
          end
        end else begin
          sprite_x <= sprite_x - step;
        end
      end
    end
  end

endmodule
